// File: rtl/beta_mem_decode.sv
// Beta memory-port address decoder and shared write-buffer bank controller.
// Decodes regions, drives write enables, and runs the projector bank-swap handshake.
module beta_mem_decode #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       beta_ma,
  input  logic              beta_moe,
  input  logic              beta_wr,
  input  logic [31:0]       beta_mdout,
  output logic [2:0]        read_select,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              ram_we,
  output logic              shared_write_we,
  output logic              shared_bank,
  output logic [31:0]       IO_dout,
  input  logic              proj_frame_end,
  output logic              swap_pending
);

  localparam int unsigned REGION_W = 2;
  localparam int unsigned FC_W     = 16;

  localparam logic [1:0] REG_RAM    = 2'd0;
  localparam logic [1:0] REG_IO     = 2'd1;
  localparam logic [1:0] REG_SH_WR  = 2'd3;

  localparam logic [1:0] IO_STATUS  = 2'd0;
  localparam logic [1:0] IO_CONTROL = 2'd1;
  localparam logic [1:0] IO_FCOUNT  = 2'd2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_SWAP    = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [FC_W-1:0]     frame_count;
  logic                overrun;
  logic [REGION_W-1:0] region;
  logic [1:0]          io_offset;
  logic                io_wr;
  logic                ctrl_swap_req;
  logic                fc_clear;
  logic                status_rd;
  logic                sh_wr_drop;
  logic [31:0]         io_rdata;
  logic                unused_bits;

  // Address decode: bits above 15 alias, byte offset ignored.
  assign region      = beta_ma[15:14];
  assign read_select = {1'b0, region};
  assign mem_addr    = beta_ma[ADDR_W+1:2];
  assign io_offset   = mem_addr[1:0];

  assign unused_bits = ^{beta_ma, beta_mdout};

  assign ram_we          = beta_wr & (region == REG_RAM) & ~reset;
  assign shared_write_we = beta_wr & (region == REG_SH_WR) & (state == ST_IDLE) & ~reset;

  assign io_wr         = beta_wr & (region == REG_IO);
  assign ctrl_swap_req = io_wr & (io_offset == IO_CONTROL) & beta_mdout[0];
  assign fc_clear      = io_wr & (io_offset == IO_FCOUNT);
  assign status_rd     = beta_moe & (region == REG_IO) & (io_offset == IO_STATUS);
  assign sh_wr_drop    = beta_wr & (region == REG_SH_WR) & (state != ST_IDLE);

  assign swap_pending = (state != ST_IDLE);

  // IO read data for the currently presented address.
  always_comb begin
    io_rdata = 32'd0;
    case (io_offset)
      IO_STATUS: io_rdata = {13'd0, overrun, swap_pending, shared_bank, frame_count};
      IO_FCOUNT: io_rdata = {16'd0, frame_count};
      default:   io_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Swap handshake: a frame-end pulse only counts once a request is pending.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (ctrl_swap_req) state_next = ST_PENDING;
      ST_PENDING: if (proj_frame_end) state_next = ST_SWAP;
      ST_SWAP:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shared_bank <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
      IO_dout     <= 32'd0;
    end else begin
      if (state == ST_SWAP) begin
        shared_bank <= ~shared_bank;
      end
      // A software clear takes priority over a coincident swap increment.
      if (fc_clear) begin
        frame_count <= '0;
      end else if (state == ST_SWAP) begin
        frame_count <= frame_count + FC_W'(1);
      end
      if (sh_wr_drop) begin
        overrun <= 1'b1;
      end else if (status_rd) begin
        overrun <= 1'b0;
      end
      if (region == REG_IO) begin
        IO_dout <= io_rdata;
      end
    end
  end

endmodule
